// File: rtl/lenet_buf_ctrl_if.sv
// Feature-memory row fetch handshake: the controller raises rd_req with a
// stable rd_addr until the memory answers with a single-cycle rd_ack.
interface lenet_buf_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;

  modport master (output rd_req, output rd_addr, input rd_ack);
  modport slave  (input rd_req, input rd_addr, output rd_ack);
endinterface

// File: rtl/lenet_buf_ctrl.sv
// Sequencer for the LeNet input line buffer: fetches operand rows and drives
// en/cur_state/ker_row/ker_col so every conv load lands on ker_cnt==10.
module lenet_buf_ctrl #(
  parameter int ADDR_W = 10,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        layer,
  input  logic [PASS_W-1:0] passes,
  input  logic [ADDR_W-1:0] base_addr,
  lenet_buf_ctrl_if.master  rd,
  output logic              en,
  output logic [3:0]        cur_state,
  output logic [3:0]        ker_row,
  output logic [3:0]        ker_col,
  output logic              mac_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] SCONV_1 = 4'd1;
  localparam logic [3:0] SCONV_2 = 4'd2;
  localparam logic [3:0] SFC_1   = 4'd3;
  localparam logic [3:0] SFC_2   = 4'd4;
  localparam logic [3:0] SFC_3   = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_FETCH, S_COMP, S_PAD, S_FCMAC, S_DONE
  } state_t;

  state_t            state;
  logic              en_r;
  logic [3:0]        ph;
  logic [2:0]        cnt;
  logic [PASS_W-1:0] pass_cnt;
  logic [PASS_W-1:0] passes_q;
  logic [3:0]        code_q;
  logic              conv_q;
  logic              last_pass;

  function automatic logic [3:0] layer_code(input logic [2:0] l);
    case (l)
      3'd0:    layer_code = SCONV_1;
      3'd1:    layer_code = SCONV_2;
      3'd2:    layer_code = SFC_1;
      3'd3:    layer_code = SFC_2;
      3'd4:    layer_code = SFC_3;
      default: layer_code = IDLE;
    endcase
  endfunction

  // The load cycle enables the buffer only when memory answers.
  assign en        = en_r | (rd.rd_req & rd.rd_ack);
  assign last_pass = (pass_cnt + PASS_W'(1)) == passes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd.rd_req  <= 1'b0;
      rd.rd_addr <= '0;
      en_r       <= 1'b0;
      cur_state  <= IDLE;
      ker_row    <= '0;
      ker_col    <= '0;
      mac_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ph         <= '0;
      cnt        <= '0;
      pass_cnt   <= '0;
      passes_q   <= '0;
      code_q     <= IDLE;
      conv_q     <= 1'b0;
    end else begin
      // ph tracks the buffer's ker_cnt; 0 stands for ker_cnt==10
      if (en) ph <= (ph == 4'd9) ? '0 : ph + 4'd1;

      case (state)
        S_IDLE: if (start) begin
          busy       <= 1'b1;
          code_q     <= layer_code(layer);
          conv_q     <= (layer < 3'd2);
          passes_q   <= passes;
          pass_cnt   <= '0;
          rd.rd_addr <= base_addr;
          ker_row    <= '0;
          cnt        <= '0;
          if (passes == '0 || layer_code(layer) == IDLE) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cur_state <= layer_code(layer);
          end else if (layer < 3'd2 && ph != '0) begin
            // Burn en cycles with cur_state=IDLE so in_r is untouched.
            state <= S_ALIGN;
            en_r  <= 1'b1;
          end else begin
            state     <= S_FETCH;
            rd.rd_req <= 1'b1;
            cur_state <= layer_code(layer);
          end
        end

        S_ALIGN: if (ph == 4'd9) begin
          state     <= S_FETCH;
          en_r      <= 1'b0;
          rd.rd_req <= 1'b1;
          cur_state <= code_q;
        end

        S_FETCH: if (rd.rd_ack) begin
          rd.rd_req  <= 1'b0;
          rd.rd_addr <= rd.rd_addr + ADDR_W'(1);
          mac_valid  <= 1'b1;
          ker_col    <= '0;
          cnt        <= '0;
          if (conv_q) begin
            state <= S_COMP;
            en_r  <= 1'b1;
          end else begin
            state <= S_FCMAC;
          end
        end

        S_COMP: begin
          if (cnt == 3'd4) begin
            state     <= S_PAD;
            mac_valid <= 1'b0;
            ker_col   <= '0;
            cnt       <= '0;
          end else begin
            cnt     <= cnt + 3'd1;
            ker_col <= ker_col + 4'd1;
          end
        end

        S_PAD: begin
          if (cnt == 3'd3) begin
            en_r <= 1'b0;
            if (ker_row != 4'd4) begin
              ker_row   <= ker_row + 4'd1;
              state     <= S_FETCH;
              rd.rd_req <= 1'b1;
            end else begin
              ker_row <= '0;
              if (last_pass) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                pass_cnt  <= pass_cnt + PASS_W'(1);
                state     <= S_FETCH;
                rd.rd_req <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        S_FCMAC: begin
          mac_valid <= 1'b0;
          if (last_pass) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            pass_cnt  <= pass_cnt + PASS_W'(1);
            state     <= S_FETCH;
            rd.rd_req <= 1'b1;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cur_state <= IDLE;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
